alu_control_seq: RTL
====================

ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 32, number of iterate cycles for MULTU (range 1..255).
REQ-002 SHALL have parameter DIV_CYCLES, default 32, number of iterate cycles for DIVU (range 1..255).
REQ-003 SHALL have parameter CNT_W, default 8, counter width, SHALL be >= clog2(max(MUL_CYCLES,DIV_CYCLES)+1).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request: funct valid this cycle.
REQ-007 funct  input  6  operation code: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2, MULTU 25, DIVU 27, MFHI 16, MFLO 18.
REQ-008 flush  input  1  synchronous abort of any multi-cycle operation.
REQ-009 busy  output  1  high while a multi-cycle operation occupies the block.
REQ-010 done  output  1  one-cycle pulse when an accepted operation completes.
REQ-011 illegal  output  1  one-cycle pulse when an undefined funct is accepted.
REQ-012 sig_alu, sig_sht, sig_mul, sig_div  output  6 each  registered control codes to ALU, shifter, multiplier, divider.
REQ-013 sig_mux  output  2  registered result-mux select.
REQ-014 hilo_we  output  1  one-cycle HiLo register write strobe.
REQ-015 cycle_cnt  output  CNT_W  current iterate-cycle count.

Function
REQ-016 States SHALL be IDLE, MUL, DIV, WB; all outputs registered.
REQ-017 start SHALL be accepted only in IDLE; start in MUL/DIV/WB SHALL be ignored with no output change.
REQ-018 IDLE, start, single-cycle funct (AND/OR/ADD/SUB/SLT/SRL/MFHI/MFLO): next cycle sig_alu=sig_sht=sig_mul=sig_div=funct, done=1, remain IDLE.
REQ-019 sig_mux SHALL be 01 for MFHI, 10 for MFLO, 11 for SRL, 00 otherwise, registered with the same cycle as sig_*.
REQ-020 IDLE, start, MULTU: go to MUL, cycle_cnt<=1, sig_mul=sig_*=25 next cycle, busy=1.
REQ-021 In MUL, cycle_cnt SHALL increment by 1 per cycle; when cycle_cnt==MUL_CYCLES, next state WB.
REQ-022 DIVU SHALL behave as REQ-020/021 with state DIV, code 27, limit DIV_CYCLES.
REQ-023 WB SHALL last exactly one cycle: sig_*=6'b111111, hilo_we=1, done=1, busy=1, cycle_cnt<=0; then IDLE with busy=0.
REQ-024 MULTU latency: start cycle N -> hilo_we/done at cycle N+MUL_CYCLES+1.
REQ-025 Undefined funct accepted in IDLE: sig_*=0, sig_mux=00, illegal=1, done=1, remain IDLE.
REQ-026 flush in MUL/DIV/WB: next cycle IDLE, cycle_cnt=0, sig_*=0, busy=0, no hilo_we, no done.
REQ-027 flush and start in same IDLE cycle: flush wins, start dropped, outputs 0.
REQ-028 Without start or accepted op in IDLE, sig_*, sig_mux SHALL return to 0 and done/illegal/hilo_we SHALL be 0.
REQ-029 cycle_cnt SHALL never exceed the active limit nor wrap; it is 0 in IDLE.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, cycle_cnt=0, busy=0, done=0, illegal=0, hilo_we=0, sig_*=0, sig_mux=00.
REQ-031 Reset asserted mid-MUL/DIV SHALL abort with no hilo_we; first accepted start after rst_n rises SHALL behave as from reset.

Verification
REQ-032 start, funct=32 -> next cycle sig_alu=32, sig_mux=00, done=1, busy=0.
REQ-033 start, funct=25 (MUL_CYCLES=32) -> busy 33 cycles, cycle_cnt 1..32, hilo_we=done=1 and sig_*=63 exactly at cycle 33.
REQ-034 funct=25 running, start funct=18 at cycle 10 -> ignored, completion unchanged at cycle 33.
REQ-035 funct=27 running, flush at cycle 5 -> next cycle busy=0, cycle_cnt=0, no hilo_we, no done.
REQ-036 start, funct=63 -> illegal=1, done=1, sig_*=0; then start funct=16 -> sig_mux=01.
REQ-037 rst_n low at cycle 20 of MULTU -> all outputs 0 asynchronously; no hilo_we after release.

Source files
------------

// File: rtl/alu_control_seq.sv
// Control sequencer for an ALU datapath: single-cycle ops complete in IDLE,
// MULTU/DIVU iterate in MUL/DIV, then write HiLo from a one-cycle WB state.
module alu_control_seq #(
  parameter int MUL_CYCLES = 32,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [5:0]       i_funct,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_illegal,
  output logic [5:0]       o_sig_alu,
  output logic [5:0]       o_sig_sht,
  output logic [5:0]       o_sig_mul,
  output logic [5:0]       o_sig_div,
  output logic [1:0]       o_sig_mux,
  output logic             o_hilo_we,
  output logic [CNT_W-1:0] o_cycle_cnt
);

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] SIG_WB  = 6'b111111;

  localparam logic [CNT_W-1:0] MUL_LIM = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LIM = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [5:0]       r_sig, w_sig_nx;
  logic [1:0]       r_mux, w_mux_nx;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;
  logic             r_illegal, w_illegal_nx;
  logic             r_hilo_we, w_hilo_we_nx;

  // Next state and next registered outputs; everything defaults to the idle/zero pattern.
  always_comb begin
    w_state_nx   = ST_IDLE;
    w_cnt_nx     = CNT_ZERO;
    w_sig_nx     = 6'd0;
    w_mux_nx     = 2'b00;
    w_busy_nx    = 1'b0;
    w_done_nx    = 1'b0;
    w_illegal_nx = 1'b0;
    w_hilo_we_nx = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_flush) begin
          w_state_nx = ST_IDLE;
        end else if (i_start) begin
          case (i_funct)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL, F_MFHI, F_MFLO: begin
              w_sig_nx  = i_funct;
              w_done_nx = 1'b1;
              case (i_funct)
                F_MFHI:  w_mux_nx = 2'b01;
                F_MFLO:  w_mux_nx = 2'b10;
                F_SRL:   w_mux_nx = 2'b11;
                default: w_mux_nx = 2'b00;
              endcase
            end
            F_MULTU: begin
              w_state_nx = ST_MUL;
              w_cnt_nx   = CNT_ONE;
              w_sig_nx   = F_MULTU;
              w_busy_nx  = 1'b1;
            end
            F_DIVU: begin
              w_state_nx = ST_DIV;
              w_cnt_nx   = CNT_ONE;
              w_sig_nx   = F_DIVU;
              w_busy_nx  = 1'b1;
            end
            default: begin
              w_illegal_nx = 1'b1;
              w_done_nx    = 1'b1;
            end
          endcase
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (i_flush) begin
          w_state_nx = ST_IDLE;
        end else if (r_cnt == ((r_state == ST_MUL) ? MUL_LIM : DIV_LIM)) begin
          w_state_nx   = ST_WB;
          w_sig_nx     = SIG_WB;
          w_hilo_we_nx = 1'b1;
          w_done_nx    = 1'b1;
          w_busy_nx    = 1'b1;
        end else begin
          // Hold the op code while iterating; a start here is simply not looked at.
          w_state_nx = r_state;
          w_cnt_nx   = r_cnt + CNT_ONE;
          w_sig_nx   = r_sig;
          w_busy_nx  = 1'b1;
        end
      end
      ST_WB: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= CNT_ZERO;
      r_sig     <= 6'd0;
      r_mux     <= 2'b00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_hilo_we <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_sig     <= w_sig_nx;
      r_mux     <= w_mux_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      r_illegal <= w_illegal_nx;
      r_hilo_we <= w_hilo_we_nx;
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_illegal   = r_illegal;
  assign o_sig_alu   = r_sig;
  assign o_sig_sht   = r_sig;
  assign o_sig_mul   = r_sig;
  assign o_sig_div   = r_sig;
  assign o_sig_mux   = r_mux;
  assign o_hilo_we   = r_hilo_we;
  assign o_cycle_cnt = r_cnt;

endmodule
